filter_capture_buffer: RTL and testbench

FILTER_CAPTURE_BUFFER -- requirements
Module: filter_capture_buffer

---
 rtl/filter_capture_buffer_if.sv | 31 +++
 rtl/filter_capture_buffer.sv | 210 +++++++++++++++++++++
 tb/tb_filter_capture_buffer.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/filter_capture_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : filter_capture_buffer_if
//  Description : AXI4-Stream slave bundle feeding the capture buffer. Each
//                128-bit beat carries eight 16-bit lanes, and each lane holds
//                a 12-bit sample in its upper bits.
//  Revision    : 1.0 - initial release
//
//  Signals:
//    s_tdata  [127:0] : beat payload
//    s_tvalid         : beat valid
//    s_tready         : beat accept (driven by the buffer)
// ============================================================================
interface filter_capture_buffer_if;
  logic [127:0] s_tdata;
  logic         s_tvalid;
  logic         s_tready;

  modport master (
    output s_tdata,
    output s_tvalid,
    input  s_tready
  );

  modport slave (
    input  s_tdata,
    input  s_tvalid,
    output s_tready
  );
endinterface
`default_nettype wire

// File: rtl/filter_capture_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : filter_capture_buffer
//  Description : Pre/post-trigger capture buffer for packed 12-bit filter
//                samples. Incoming 128-bit beats are unpacked to 96-bit words
//                and written circularly into a DEPTH-entry memory. After an
//                arm request, the buffer prefills PRETRIG words, waits for a
//                trigger, and then stores DEPTH-PRETRIG more words. The record
//                can then be read back through a registered read port.
//  Revision    : 1.0 - initial release
//
//  Ports:
//    aclk          in   1      sole clock, rising edge
//    aresetn       in   1      asynchronous active-low reset
//    s_axis        slave       AXI4-Stream input (never stalls once out of reset)
//    arm_i         in   1      arm request (honoured in IDLE and DONE)
//    trig_i        in   1      trigger level, honoured only in ARMED
//    rd_addr_i     in   AW     readout address
//    rd_data_o     out  96     mem[rd_addr_i], one cycle latency
//    armed_o       out  1      capture in progress (PREFILL/ARMED/POST)
//    done_o        out  1      record complete
//    start_addr_o  out  AW     address of the oldest word of the record
// ============================================================================
module filter_capture_buffer #(
  parameter int DEPTH   = 1024,
  parameter int PRETRIG = 256,
  localparam int AW     = $clog2(DEPTH)
) (
  input  wire logic            aclk,
  input  wire logic            aresetn,
  filter_capture_buffer_if.slave s_axis,
  input  wire logic            arm_i,
  input  wire logic            trig_i,
  input  wire logic [AW-1:0]   rd_addr_i,
  output logic      [95:0]     rd_data_o,
  output logic                 armed_o,
  output logic                 done_o,
  output logic      [AW-1:0]   start_addr_o
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_PREFILL = 3'd1;
  localparam logic [2:0] ST_ARMED   = 3'd2;
  localparam logic [2:0] ST_POST    = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam logic [AW-1:0] PRETRIG_C  = AW'(PRETRIG);
  localparam logic [AW-1:0] POST_LEN_C = AW'(DEPTH - PRETRIG);

  // --------------------------------------------------------------------------
  // State and storage
  // --------------------------------------------------------------------------
  logic [2:0]    state_q,      state_d;
  logic [AW-1:0] wr_ptr_q,     wr_ptr_d;
  // Shared counter: beats stored in PREFILL, beats remaining in POST.
  logic [AW-1:0] cnt_q,        cnt_d;
  logic [AW-1:0] trig_addr_q,  trig_addr_d;
  logic [AW-1:0] start_addr_q, start_addr_d;
  logic          tready_q;
  logic [95:0]   rd_data_q;
  logic [95:0]   mem_q [DEPTH];

  logic          w_beat;
  logic          w_wr_en;
  logic [95:0]   w_unpacked;
  logic [AW-1:0] w_post_rem;
  logic          w_unused_pad;

  assign w_beat = s_axis.s_tvalid & tready_q;

  // --------------------------------------------------------------------------
  // Lane unpacking: keep the 12-bit sample, drop the 4 padding bits.
  // --------------------------------------------------------------------------
  logic [31:0] w_pad_bits;

  for (genvar gi = 0; gi < 8; gi++) begin : g_unpack
    assign w_unpacked[12*gi +: 12] = s_axis.s_tdata[16*gi+4 +: 12];
    assign w_pad_bits[4*gi +: 4]   = s_axis.s_tdata[16*gi +: 4];
  end

  // Padding is intentionally discarded; fold it into a sink signal.
  assign w_unused_pad = ^w_pad_bits;

  // Remaining POST beats after the trigger cycle. The trigger-cycle beat
  // counts as the first POST beat.
  assign w_post_rem = w_beat ? (POST_LEN_C - 1'b1) : POST_LEN_C;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;
    trig_addr_d  = trig_addr_q;
    start_addr_d = start_addr_q;
    w_wr_en      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (arm_i) begin
          state_d  = ST_PREFILL;
          wr_ptr_d = '0;
          cnt_d    = '0;
        end
      end

      ST_PREFILL: begin
        if (w_beat) begin
          w_wr_en  = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q + 1'b1 == PRETRIG_C) begin
            state_d = ST_ARMED;
          end
        end
      end

      ST_ARMED: begin
        if (w_beat) begin
          w_wr_en  = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (trig_i) begin
          trig_addr_d = wr_ptr_q;
          cnt_d       = w_post_rem;
          if (w_post_rem == '0) begin
            // Only reachable when DEPTH-PRETRIG is 1.
            state_d      = ST_DONE;
            start_addr_d = wr_ptr_q - PRETRIG_C;
          end else begin
            state_d = ST_POST;
          end
        end
      end

      ST_POST: begin
        if (w_beat) begin
          w_wr_en  = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          cnt_d    = cnt_q - 1'b1;
          if (cnt_q == AW'(1)) begin
            state_d      = ST_DONE;
            start_addr_d = trig_addr_q - PRETRIG_C;
          end
        end
      end

      ST_DONE: begin
        if (arm_i) begin
          state_d  = ST_PREFILL;
          wr_ptr_d = '0;
          cnt_d    = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
      tready_q     <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      trig_addr_q  <= trig_addr_d;
      start_addr_q <= start_addr_d;
      tready_q     <= 1'b1;
      // Read-before-write: a same-cycle write to rd_addr_i is seen next read.
      rd_data_q    <= mem_q[rd_addr_i];
    end
  end

  // --------------------------------------------------------------------------
  // Capture memory (not reset)
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (w_wr_en) begin
      mem_q[wr_ptr_q] <= w_unpacked;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign s_axis.s_tready = tready_q;
  assign rd_data_o       = rd_data_q;
  assign armed_o         = (state_q == ST_PREFILL) || (state_q == ST_ARMED) ||
                           (state_q == ST_POST);
  assign done_o          = (state_q == ST_DONE);
  assign start_addr_o    = start_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_filter_capture_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_filter_capture_buffer
//  Description : Self-checking bench for filter_capture_buffer with
//                DEPTH=16, PRETRIG=4. The reference model is a capture record
//                made of queues. Pre-trigger beats and post-trigger beats are
//                collected separately. The finished record is laid out in a
//                memory image starting at the oldest retained beat.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_filter_capture_buffer;
  localparam int DEPTH   = 16;
  localparam int PRETRIG = 4;
  localparam int AW      = 4;
  localparam int POST    = DEPTH - PRETRIG;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          arm_i = 1'b0;
  logic          trig_i = 1'b0;
  logic [AW-1:0] rd_addr_i = '0;
  logic [95:0]   rd_data_o;
  logic          armed_o;
  logic          done_o;
  logic [AW-1:0] start_addr_o;

  filter_capture_buffer_if axis ();

  filter_capture_buffer #(.DEPTH(DEPTH), .PRETRIG(PRETRIG)) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .s_axis       (axis.slave),
    .arm_i        (arm_i),
    .trig_i       (trig_i),
    .rd_addr_i    (rd_addr_i),
    .rd_data_o    (rd_data_o),
    .armed_o      (armed_o),
    .done_o       (done_o),
    .start_addr_o (start_addr_o)
  );

  always #5 aclk = ~aclk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model
  bit          m_ready, m_active, m_trig, m_done;
  logic [95:0] m_pre[$];
  logic [95:0] m_post[$];
  logic [95:0] exp_mem [DEPTH];
  int          m_start;

  function automatic logic [127:0] mk_beat(input logic [11:0] v, input logic [3:0] pad);
    logic [127:0] d;
    for (int i = 0; i < 8; i++) d[16*i +: 16] = {v, pad};
    return d;
  endfunction

  function automatic logic [95:0] unpack(input logic [127:0] d);
    logic [95:0] w;
    for (int i = 0; i < 8; i++) w[12*i +: 12] = d[16*i+4 +: 12];
    return w;
  endfunction

  function automatic logic [95:0] rep(input int k);
    logic [11:0] v;
    v = 12'(k);
    return {8{v}};
  endfunction

  // Record completes: oldest retained beat is PRETRIG before the trigger.
  task automatic commit_record();
    int n;
    n = m_pre.size();
    m_start = (n - PRETRIG) % DEPTH;
    for (int j = 0; j < PRETRIG; j++)
      exp_mem[(m_start + j) % DEPTH] = m_pre[n - PRETRIG + j];
    for (int j = 0; j < POST; j++)
      exp_mem[(m_start + PRETRIG + j) % DEPTH] = m_post[j];
  endtask

  // One clock: apply inputs, advance the model, sample #1 after the edge.
  task automatic step(input bit valid, input logic [127:0] data, input bit trig, input bit arm);
    bit beat;
    axis.s_tvalid = valid;
    axis.s_tdata  = data;
    trig_i        = trig;
    arm_i         = arm;
    beat          = valid && m_ready;
    if (arm && (!m_active || m_done)) begin
      m_active = 1; m_trig = 0; m_done = 0;
      m_pre.delete(); m_post.delete();
    end else if (m_active && !m_done) begin
      if (!m_trig) begin
        if (trig && m_pre.size() >= PRETRIG) begin
          m_trig = 1;
          if (beat) m_post.push_back(unpack(data));
        end else if (beat) begin
          m_pre.push_back(unpack(data));
        end
      end else if (beat) begin
        m_post.push_back(unpack(data));
      end
      if (m_trig && m_post.size() == POST) begin
        m_done = 1;
        commit_record();
      end
    end
    @(posedge aclk);
    m_ready = (aresetn === 1'b1);
    #1;
    axis.s_tvalid = 1'b0;
    trig_i        = 1'b0;
    arm_i         = 1'b0;
  endtask

  task automatic read_word(input logic [AW-1:0] a, output logic [95:0] d);
    rd_addr_i = a;
    step(1'b0, '0, 1'b0, 1'b0);
    d = rd_data_o;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    m_ready = 0; m_active = 0; m_done = 0; m_trig = 0;
    repeat (2) @(posedge aclk);
    #1;
    n_vec++; if (axis.s_tready !== 1'b0) begin n_err++; $display("FAIL reset_tready got %b want 0", axis.s_tready); end
    n_vec++; if (armed_o !== 1'b0) begin n_err++; $display("FAIL reset_armed got %b want 0", armed_o); end
    n_vec++; if (done_o !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done_o); end
    n_vec++; if (start_addr_o !== '0) begin n_err++; $display("FAIL reset_start got %0d want 0", start_addr_o); end
    n_vec++; if (rd_data_o !== '0) begin n_err++; $display("FAIL reset_rdata got %h want 0", rd_data_o); end
    aresetn = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);
    n_vec++; if (axis.s_tready !== 1'b1) begin n_err++; $display("FAIL release_tready got %b want 1", axis.s_tready); end
    n_vec++; if (armed_o !== 1'b0 || done_o !== 1'b0) begin n_err++; $display("FAIL release_idle got armed=%b done=%b want 0/0", armed_o, done_o); end
  endtask

  task automatic test_basic_capture();
    logic [95:0] d;
    step(1'b0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) step(1'b1, mk_beat(12'(k), 4'h0), 1'b0, 1'b0);
    n_vec++; if (armed_o !== 1'b1) begin n_err++; $display("FAIL basic_armed got %b want 1", armed_o); end
    step(1'b1, mk_beat(12'd10, 4'h0), 1'b1, 1'b0);
    for (int k = 11; k < 22; k++) begin
      step(1'b1, mk_beat(12'(k), 4'h0), 1'b0, 1'b0);
      if (k == 20) begin
        n_vec++; if (done_o !== 1'b0 || armed_o !== 1'b1) begin n_err++; $display("FAIL basic_before_last got done=%b armed=%b want 0/1", done_o, armed_o); end
      end
    end
    n_vec++; if (done_o !== 1'b1 || armed_o !== 1'b0) begin n_err++; $display("FAIL basic_done got done=%b armed=%b want 1/0", done_o, armed_o); end
    n_vec++; if (start_addr_o !== 4'd6) begin n_err++; $display("FAIL basic_start got %0d want 6", start_addr_o); end
    for (int j = 0; j < DEPTH; j++) begin
      read_word(AW'((6 + j) % DEPTH), d);
      n_vec++; if (d !== rep(6 + j)) begin n_err++; $display("FAIL basic_read[%0d] got %h want %h", (6 + j) % DEPTH, d, rep(6 + j)); end
    end
  endtask

  task automatic test_early_trigger();
    logic [95:0] d;
    step(1'b0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b1, mk_beat(12'(k), 4'h0), 1'b1, 1'b0);
    n_vec++; if (armed_o !== 1'b1) begin n_err++; $display("FAIL early_armed got %b want 1", armed_o); end
    step(1'b1, mk_beat(12'd4, 4'h0), 1'b0, 1'b0);
    step(1'b1, mk_beat(12'd5, 4'h0), 1'b1, 1'b0);
    for (int k = 6; k < 17; k++) step(1'b1, mk_beat(12'(k), 4'h0), 1'b0, 1'b0);
    n_vec++; if (done_o !== 1'b1) begin n_err++; $display("FAIL early_done got %b want 1", done_o); end
    n_vec++; if (start_addr_o !== 4'd1) begin n_err++; $display("FAIL early_start got %0d want 1", start_addr_o); end
    for (int j = 0; j < DEPTH; j++) begin
      read_word(AW'(j), d);
      n_vec++; if (d !== exp_mem[j]) begin n_err++; $display("FAIL early_read[%0d] got %h want %h", j, d, exp_mem[j]); end
    end
  endtask

  task automatic test_valid_gaps();
    logic [95:0] d;
    int nb;
    step(1'b0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b1, mk_beat(12'(40 + k), 4'h0), 1'b0, 1'b0);
    step(1'b1, mk_beat(12'd44, 4'h0), 1'b1, 1'b0);
    nb = 1;
    for (int c = 0; nb < POST && c < 100; c++) begin
      if (c % 2 == 0) begin
        step(1'b0, mk_beat(12'hFFF, 4'h0), 1'b0, 1'b0);
      end else begin
        step(1'b1, mk_beat(12'(44 + nb), 4'h0), 1'b0, 1'b0);
        nb++;
      end
      if (nb < POST) begin
        n_vec++; if (done_o !== 1'b0 || armed_o !== 1'b1) begin n_err++; $display("FAIL gaps_mid got done=%b armed=%b want 0/1", done_o, armed_o); end
      end
    end
    n_vec++; if (done_o !== 1'b1) begin n_err++; $display("FAIL gaps_done got %b want 1", done_o); end
    n_vec++; if (start_addr_o !== 4'd0) begin n_err++; $display("FAIL gaps_start got %0d want 0", start_addr_o); end
    for (int j = 0; j < DEPTH; j++) begin
      read_word(AW'(j), d);
      n_vec++; if (d !== rep(40 + j)) begin n_err++; $display("FAIL gaps_read[%0d] got %h want %h", j, d, rep(40 + j)); end
    end
  endtask

  task automatic test_read_during_write();
    logic [95:0] old0;
    logic [95:0] d;
    old0 = exp_mem[0];
    step(1'b0, '0, 1'b0, 1'b1);
    rd_addr_i = '0;
    step(1'b1, mk_beat(12'h055, 4'h3), 1'b0, 1'b0);
    n_vec++; if (rd_data_o !== old0) begin n_err++; $display("FAIL rdw_old got %h want %h", rd_data_o, old0); end
    read_word('0, d);
    n_vec++; if (d !== rep(12'h055)) begin n_err++; $display("FAIL rdw_new got %h want %h", d, rep(12'h055)); end
    for (int k = 1; k < 4; k++) step(1'b1, mk_beat(12'(k), 4'h0), 1'b0, 1'b0);
    step(1'b1, mk_beat(12'd4, 4'h0), 1'b1, 1'b0);
    for (int k = 5; k < 16; k++) step(1'b1, mk_beat(12'(k), 4'h0), 1'b0, 1'b0);
    n_vec++; if (done_o !== 1'b1) begin n_err++; $display("FAIL rdw_done got %b want 1", done_o); end
  endtask

  task automatic test_unpack();
    logic [95:0] d;
    step(1'b0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b1, {8{16'hABCF}}, 1'b0, 1'b0);
    for (int k = 4; k < 16; k++) step(1'b1, {8{16'hABCF}}, k == 4, 1'b0);
    n_vec++; if (done_o !== 1'b1) begin n_err++; $display("FAIL unpack_done got %b want 1", done_o); end
    for (int j = 0; j < DEPTH; j++) begin
      read_word(AW'(j), d);
      n_vec++; if (d !== {8{12'hABC}}) begin n_err++; $display("FAIL unpack_read[%0d] got %h want %h", j, d, {8{12'hABC}}); end
    end
  endtask

  task automatic test_reset_abort();
    logic [95:0] d;
    step(1'b0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b1, mk_beat(12'(200 + k), 4'h0), 1'b0, 1'b0);
    step(1'b1, mk_beat(12'd204, 4'h0), 1'b1, 1'b0);
    for (int k = 5; k < 8; k++) step(1'b1, mk_beat(12'(200 + k), 4'h0), 1'b0, 1'b0);
    aresetn = 1'b0;
    m_ready = 0; m_active = 0; m_done = 0; m_trig = 0;
    #1;
    n_vec++; if (armed_o !== 1'b0 || done_o !== 1'b0) begin n_err++; $display("FAIL abort_state got armed=%b done=%b want 0/0", armed_o, done_o); end
    n_vec++; if (axis.s_tready !== 1'b0) begin n_err++; $display("FAIL abort_tready got %b want 0", axis.s_tready); end
    @(posedge aclk); #1;
    aresetn = 1'b1;
    for (int k = 0; k < 3; k++) step(1'b1, mk_beat(12'(300 + k), 4'h0), 1'b1, 1'b0);
    n_vec++; if (armed_o !== 1'b0 || done_o !== 1'b0) begin n_err++; $display("FAIL abort_idle got armed=%b done=%b want 0/0", armed_o, done_o); end
    read_word('0, d);
    n_vec++; if (d !== rep(200)) begin n_err++; $display("FAIL abort_nowrite got %h want %h", d, rep(200)); end
    step(1'b0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) step(1'b1, mk_beat(12'(100 + k), 4'h0), 1'b0, 1'b0);
    step(1'b1, mk_beat(12'd106, 4'h0), 1'b1, 1'b0);
    for (int k = 7; k < 18; k++) step(1'b1, mk_beat(12'(100 + k), 4'h0), 1'b0, 1'b0);
    n_vec++; if (done_o !== 1'b1) begin n_err++; $display("FAIL abort_redone got %b want 1", done_o); end
    n_vec++; if (start_addr_o !== 4'd2) begin n_err++; $display("FAIL abort_start got %0d want 2", start_addr_o); end
    for (int j = 0; j < DEPTH; j++) begin
      read_word(AW'((2 + j) % DEPTH), d);
      n_vec++; if (d !== rep(102 + j)) begin n_err++; $display("FAIL abort_read[%0d] got %h want %h", (2 + j) % DEPTH, d, rep(102 + j)); end
    end
  endtask

  task automatic test_random();
    logic [95:0] d;
    logic [127:0] data;
    for (int it = 0; it < 6; it++) begin
      step(1'b0, '0, 1'b0, 1'b1);
      for (int c = 0; c < 400 && !m_done; c++) begin
        data = {$urandom, $urandom, $urandom, $urandom};
        step($urandom_range(0, 3) != 0, data, $urandom_range(0, 7) == 0,
             $urandom_range(0, 15) == 0);
        n_vec++;
        if (armed_o !== (m_active && !m_done) || done_o !== m_done) begin
          n_err++;
          $display("FAIL rand_state it=%0d c=%0d got armed=%b done=%b want %b/%b",
                   it, c, armed_o, done_o, m_active && !m_done, m_done);
        end
      end
      if (!m_done) begin
        n_vec++; n_err++;
        $display("FAIL rand_timeout it=%0d got done=%b want 1", it, done_o);
      end else begin
        n_vec++; if (start_addr_o !== AW'(m_start)) begin n_err++; $display("FAIL rand_start it=%0d got %0d want %0d", it, start_addr_o, m_start); end
        for (int j = 0; j < DEPTH; j++) begin
          read_word(AW'(j), d);
          n_vec++; if (d !== exp_mem[j]) begin n_err++; $display("FAIL rand_read it=%0d [%0d] got %h want %h", it, j, d, exp_mem[j]); end
        end
      end
    end
  endtask

  initial begin
    axis.s_tdata  = '0;
    axis.s_tvalid = 1'b0;
    test_reset();
    test_basic_capture();
    test_early_trigger();
    test_valid_gaps();
    test_read_during_write();
    test_unpack();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
